// File: rtl/siphash_msg_sequencer_if.sv
// Command bus between the message sequencer (master) and the SipHash core (slave).
interface siphash_msg_sequencer_if;
  logic         core_initalize;
  logic         core_compress;
  logic         core_finalize;
  logic         core_long;
  logic [3:0]   core_compression_rounds;
  logic [3:0]   core_final_rounds;
  logic [127:0] core_key;
  logic [63:0]  core_mi;
  logic         core_ready;
  logic [127:0] core_word;
  logic         core_word_valid;

  modport master (
    output core_initalize, core_compress, core_finalize, core_long,
           core_compression_rounds, core_final_rounds, core_key, core_mi,
    input  core_ready, core_word, core_word_valid
  );

  modport slave (
    input  core_initalize, core_compress, core_finalize, core_long,
           core_compression_rounds, core_final_rounds, core_key, core_mi,
    output core_ready, core_word, core_word_valid
  );
endinterface

// File: rtl/siphash_msg_sequencer.sv
// SipHash message sequencer: packs a byte stream into 64-bit little-endian
// words, appends the length-padded final block and drives the core's
// init/compress/finalize commands, then holds the digest for the host.
// Optional macro SIPHASH_SEQ_LENGTH_EN adds a 64-bit accepted-byte count
// output o_msg_len.
module siphash_msg_sequencer #(
  parameter int C_ROUNDS = 2,
  parameter int D_ROUNDS = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic [127:0] i_key,
  input  logic [7:0]   i_in_data,
  input  logic         i_in_valid,
  input  logic         i_in_last,
  output logic         o_in_ready,
  output logic         o_busy,
  output logic [63:0]  o_digest,
  output logic         o_digest_valid,
`ifdef SIPHASH_SEQ_LENGTH_EN
  output logic [63:0]  o_msg_len,
`endif
  siphash_msg_sequencer_if.master cif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_COLLECT = 3'd2;
  localparam logic [2:0] S_CISSUE  = 3'd3;
  localparam logic [2:0] S_CWAIT   = 3'd4;
  localparam logic [2:0] S_FISSUE  = 3'd5;
  localparam logic [2:0] S_FWAIT   = 3'd6;

  logic [2:0]  r_state;
  logic [63:0] r_buf;
  logic [2:0]  r_byte_cnt;
  logic [7:0]  r_len_cnt;
  logic        r_pad_pending;
  logic        r_final;
  logic        r_skip;
  logic        r_init, r_comp, r_fin;
  logic [63:0] r_mi;
  logic [63:0] r_digest;
  logic        r_dv;
  logic        r_busy;

  logic        w_take;
  logic [7:0]  w_len_nxt;
  logic [63:0] w_buf_wr;
  logic        w_unused_word_hi;

  assign w_take    = i_in_valid && (r_state == S_COLLECT);
  assign w_len_nxt = r_len_cnt + 8'd1;
  // Upper half of the core result carries nothing for 64-bit output mode.
  assign w_unused_word_hi = ^cif.core_word[127:64];

  // Buffer image after the incoming byte lands; a short final word also
  // gets the post-increment length in lane 7.
  always_comb begin
    w_buf_wr = r_buf;
    w_buf_wr[{r_byte_cnt, 3'b000} +: 8] = i_in_data;
    if (i_in_last && (r_byte_cnt != 3'd7)) w_buf_wr[63:56] = w_len_nxt;
  end

  // Main sequencer: byte collection, compress/finalize issue and digest capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_byte_cnt    <= '0;
      r_len_cnt     <= '0;
      r_pad_pending <= 1'b0;
      r_final       <= 1'b0;
      r_skip        <= 1'b0;
      r_init        <= 1'b0;
      r_comp        <= 1'b0;
      r_fin         <= 1'b0;
      r_mi          <= '0;
      r_digest      <= '0;
      r_dv          <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_init <= 1'b0;
      r_comp <= 1'b0;
      r_fin  <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_dv          <= 1'b0;
          r_busy        <= 1'b1;
          r_len_cnt     <= '0;
          r_byte_cnt    <= '0;
          r_buf         <= '0;
          r_pad_pending <= 1'b0;
          r_final       <= 1'b0;
          r_state       <= S_INIT;
        end
        S_INIT: begin
          r_init  <= 1'b1;
          r_state <= S_COLLECT;
        end
        S_COLLECT: if (w_take) begin
          r_buf      <= w_buf_wr;
          r_byte_cnt <= r_byte_cnt + 3'd1;
          r_len_cnt  <= w_len_nxt;
          if (i_in_last) begin
            // A full last word still needs a separate length-only block.
            if (r_byte_cnt == 3'd7) r_pad_pending <= 1'b1;
            else                    r_final       <= 1'b1;
            r_state <= S_CISSUE;
          end else if (r_byte_cnt == 3'd7) begin
            r_state <= S_CISSUE;
          end
        end
        S_CISSUE: if (cif.core_ready) begin
          r_comp  <= 1'b1;
          r_mi    <= r_buf;
          r_skip  <= 1'b1;
          r_state <= S_CWAIT;
        end
        S_CWAIT: begin
          // core_ready lags the compress pulse by a cycle; ignore it once.
          if (r_skip) begin
            r_skip <= 1'b0;
          end else if (cif.core_ready) begin
            if (r_pad_pending) begin
              r_buf         <= {r_len_cnt, 56'h0};
              r_pad_pending <= 1'b0;
              r_final       <= 1'b1;
              r_state       <= S_CISSUE;
            end else if (r_final) begin
              r_state <= S_FISSUE;
            end else begin
              r_buf      <= '0;
              r_byte_cnt <= '0;
              r_state    <= S_COLLECT;
            end
          end
        end
        S_FISSUE: begin
          r_fin   <= 1'b1;
          r_state <= S_FWAIT;
        end
        S_FWAIT: if (cif.core_word_valid) begin
          r_digest <= cif.core_word[63:0];
          r_dv     <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SIPHASH_SEQ_LENGTH_EN
  logic [63:0] r_msg_len;
  // Full-width accepted-byte count, cleared on each accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          r_msg_len <= '0;
    else if (r_state == S_IDLE && i_start) r_msg_len <= '0;
    else if (w_take)                       r_msg_len <= r_msg_len + 64'd1;
  end
  assign o_msg_len = r_msg_len;
`endif

  assign o_in_ready     = (r_state == S_COLLECT);
  assign o_busy         = r_busy;
  assign o_digest       = r_digest;
  assign o_digest_valid = r_dv;

  assign cif.core_initalize          = r_init;
  assign cif.core_compress           = r_comp;
  assign cif.core_finalize           = r_fin;
  assign cif.core_long               = 1'b0;
  assign cif.core_compression_rounds = 4'(C_ROUNDS);
  assign cif.core_final_rounds       = 4'(D_ROUNDS);
  assign cif.core_key                = i_key;
  assign cif.core_mi                 = r_mi;

endmodule

// File: tb/tb_siphash_msg_sequencer.sv
// Randomized bench for siphash_msg_sequencer with a behavioural SipHash core
// and a byte-level reference model of the expected words and digest.
module tb_siphash_msg_sequencer;
  typedef logic [7:0]  bq_t [$];
  typedef logic [63:0] wq_t [$];
  typedef logic [3:0][63:0] sv_t;

  localparam logic [127:0] KEY0 = 128'h0f0e0d0c0b0a0908_0706050403020100;

  logic         clk, reset_n, i_start, i_in_valid, i_in_last;
  logic [127:0] i_key;
  logic [7:0]   i_in_data;
  logic         o_in_ready, o_busy, o_digest_valid;
  logic [63:0]  o_digest;
`ifdef SIPHASH_SEQ_LENGTH_EN
  logic [63:0]  msg_len;
`endif

  siphash_msg_sequencer_if cif();

  siphash_msg_sequencer #(.C_ROUNDS(2), .D_ROUNDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_key(i_key),
    .i_in_data(i_in_data), .i_in_valid(i_in_valid), .i_in_last(i_in_last),
    .o_in_ready(o_in_ready), .o_busy(o_busy), .o_digest(o_digest),
    .o_digest_valid(o_digest_valid),
`ifdef SIPHASH_SEQ_LENGTH_EN
    .o_msg_len(msg_len),
`endif
    .cif(cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  wq_t exp_mi;
  logic [63:0] exp_dig;
  int exp_len;
  bit expect_done = 0;

  // ---------------- SipHash primitives ----------------
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic sv_t sround(input sv_t v);
    v[0] = v[0] + v[1]; v[1] = rotl(v[1], 13); v[1] ^= v[0]; v[0] = rotl(v[0], 32);
    v[2] = v[2] + v[3]; v[3] = rotl(v[3], 16); v[3] ^= v[2];
    v[0] = v[0] + v[3]; v[3] = rotl(v[3], 21); v[3] ^= v[0];
    v[2] = v[2] + v[1]; v[1] = rotl(v[1], 17); v[1] ^= v[2]; v[2] = rotl(v[2], 32);
    return v;
  endfunction

  function automatic sv_t sv_init(input logic [127:0] k);
    sv_t v;
    v[0] = k[63:0]   ^ 64'h736f6d6570736575;
    v[1] = k[127:64] ^ 64'h646f72616e646f6d;
    v[2] = k[63:0]   ^ 64'h6c7967656e657261;
    v[3] = k[127:64] ^ 64'h7465646279746573;
    return v;
  endfunction

  function automatic sv_t sv_comp(input sv_t v, input logic [63:0] m, input int r);
    v[3] ^= m;
    for (int i = 0; i < r; i++) v = sround(v);
    v[0] ^= m;
    return v;
  endfunction

  function automatic logic [63:0] sv_fin(input sv_t v, input int r);
    v[2] ^= 64'hff;
    for (int i = 0; i < r; i++) v = sround(v);
    return v[0] ^ v[1] ^ v[2] ^ v[3];
  endfunction

  // Message -> word list: full 8-byte chunks, then tail bytes with len mod 256 on top.
  function automatic wq_t build_words(input bq_t m);
    wq_t w;
    logic [63:0] x;
    int n = m.size();
    for (int i = 0; i < n / 8; i++) begin
      x = '0;
      for (int b = 0; b < 8; b++) x[8*b +: 8] = m[8*i + b];
      w.push_back(x);
    end
    x = '0;
    for (int b = 0; b < n % 8; b++) x[8*b +: 8] = m[8*(n/8) + b];
    x[63:56] = 8'(n);
    w.push_back(x);
    return w;
  endfunction

  function automatic logic [63:0] sip_ref(input logic [127:0] k, input bq_t m);
    wq_t w = build_words(m);
    sv_t v = sv_init(k);
    foreach (w[i]) v = sv_comp(v, w[i], 2);
    return sv_fin(v, 4);
  endfunction

  // ---------------- behavioural core ----------------
  sv_t cv;
  int ccnt;
  logic cfin_mode;
  logic [63:0] cres;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cv <= '0; ccnt <= 0; cfin_mode <= 1'b0; cres <= '0;
      cif.core_ready <= 1'b1; cif.core_word_valid <= 1'b0; cif.core_word <= '0;
    end else begin
      cif.core_word_valid <= 1'b0;
      if (cif.core_initalize) begin
        cv <= sv_init(cif.core_key);
      end else if (cif.core_compress) begin
        cv <= sv_comp(cv, cif.core_mi, int'(cif.core_compression_rounds));
        cif.core_ready <= 1'b0;
        ccnt <= int'(cif.core_compression_rounds) + 1 + int'($urandom_range(0, 3));
        cfin_mode <= 1'b0;
      end else if (cif.core_finalize) begin
        cres <= sv_fin(cv, int'(cif.core_final_rounds));
        cif.core_ready <= 1'b0;
        ccnt <= int'(cif.core_final_rounds) + 2 + int'($urandom_range(0, 3));
        cfin_mode <= 1'b1;
      end else if (ccnt > 0) begin
        ccnt <= ccnt - 1;
        if (ccnt == 1) begin
          cif.core_ready <= 1'b1;
          if (cfin_mode) begin
            cif.core_word_valid <= 1'b1;
            cif.core_word <= {$urandom, $urandom, cres};
          end
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: expected event did not occur or was unexpected", nm);
  endtask

  task automatic check_reset();
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_digest", o_digest, 0);
    chk("rst_digest_valid", o_digest_valid, 0);
    chk("rst_init", cif.core_initalize, 0);
    chk("rst_compress", cif.core_compress, 0);
    chk("rst_finalize", cif.core_finalize, 0);
    chk("rst_core_mi", cif.core_mi, 0);
  endtask

  // Per-cycle compare against the model.
  logic dv_q = 1'b0;
  logic [63:0] dig_q = '0;
  initial begin
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        dv_q = 1'b0;
      end else begin
        chk("core_long", cif.core_long, 0);
        chk("c_rounds", cif.core_compression_rounds, 2);
        chk("d_rounds", cif.core_final_rounds, 4);
        if (o_busy) chk("core_key", cif.core_key, i_key);
        if (!o_busy || !cif.core_ready || cif.core_compress || cif.core_finalize)
          chk("in_ready_outside_collect", o_in_ready, 0);
        chk("busy_dv_exclusive", o_busy && o_digest_valid, 0);
        if (cif.core_compress) begin
          if (exp_mi.size() == 0) flag("extra_compress");
          else begin
            w = exp_mi.pop_front();
            chk("core_mi", cif.core_mi, w);
          end
        end
        if (dv_q && o_digest_valid) chk("digest_hold", o_digest, dig_q);
        if (o_digest_valid && !dv_q) begin
          if (!expect_done) flag("unexpected_digest");
          else begin
            chk("digest", o_digest, exp_dig);
            chk("words_left", exp_mi.size(), 0);
`ifdef SIPHASH_SEQ_LENGTH_EN
            chk("msg_len", msg_len, exp_len);
`endif
            expect_done = 0;
          end
        end
        dv_q = o_digest_valid;
        dig_q = o_digest;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic feed(input bq_t m, input int gap, input bit poke, input bit use_last);
    int idx = 0;
    int guard = 0;
    bit tog = 1'b1;
    bit v, take;
    while (idx < m.size() && guard < 4000) begin
      guard++;
      case (gap)
        0: v = 1'b1;
        1: begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      i_in_valid = v;
      i_in_data  = v ? m[idx] : 8'($urandom);
      i_in_last  = v ? (use_last && idx == m.size() - 1) : 1'($urandom);
      i_start    = poke && o_busy && ($urandom_range(0, 2) == 0);
      take = v && o_in_ready;
      @(negedge clk);
      if (take) idx++;
    end
    i_in_valid = 1'b0; i_in_last = 1'b0; i_start = 1'b0;
    if (idx < m.size()) flag("feed_timeout");
  endtask

  task automatic wait_done(input bit poke);
    int c = 0;
    while (expect_done && c < 3000) begin
      i_start = poke && o_busy && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      c++;
    end
    i_start = 1'b0;
    if (expect_done) begin
      flag("digest_timeout");
      expect_done = 0;
    end
  endtask

  task automatic run_msg(input bq_t m, input int gap, input bit poke);
    exp_mi = build_words(m);
    exp_dig = sip_ref(i_key, m);
    exp_len = m.size();
    expect_done = 1;
    pulse_start();
    feed(m, gap, poke, 1'b1);
    wait_done(poke);
  endtask

  initial begin
    bq_t m, m8;
    wq_t w;
    int c;
    reset_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_in_last = 1'b0;
    i_in_data = '0; i_key = KEY0;
    #12 check_reset();
    @(negedge clk); #1 reset_n = 1'b1;

    // Pin the reference model to known SipHash-2-4 vectors.
    m = {8'h00};
    chk("pin_ref_1", sip_ref(KEY0, m), 64'h74f839c593dc67fd);
    w = build_words(m);
    chk("pin_mi_1", w[0], 64'h0100000000000000);
    m = {}; for (int i = 0; i < 8; i++) m.push_back(8'(i));
    chk("pin_ref_8", sip_ref(KEY0, m), 64'h93f5f5799a932462);
    w = build_words(m);
    chk("pin_mi_8", w[1], 64'h0800000000000000);
    m = {}; for (int i = 0; i < 15; i++) m.push_back(8'(i));
    chk("pin_ref_15", sip_ref(KEY0, m), 64'ha129ca6149be45e5);
    w = build_words(m);
    chk("pin_mi_15", w[1], 64'h0f0e0d0c0b0a0908);

    // Directed messages with the reference key.
    m = {8'h00}; run_msg(m, 0, 0);
    m = {}; for (int i = 0; i < 8; i++) m.push_back(8'(i)); run_msg(m, 0, 0);
    m = {}; for (int i = 0; i < 15; i++) m.push_back(8'(i)); run_msg(m, 0, 0);
    run_msg(m, 1, 1);

    // Reset while waiting on a compress, then recover.
    m = {}; for (int i = 0; i < 16; i++) m.push_back(8'(i));
    m8 = {}; for (int i = 0; i < 8; i++) m8.push_back(8'(i));
    exp_mi = build_words(m);
    expect_done = 0;
    pulse_start();
    feed(m8, 0, 0, 1'b0);
    c = 0;
    while (!cif.core_compress && c < 50) begin @(negedge clk); c++; end
    if (!cif.core_compress) flag("mid_compress");
    #1 reset_n = 1'b0;
    #1 check_reset();
    @(negedge clk); check_reset();
    exp_mi.delete();
    @(negedge clk); #1 reset_n = 1'b1;
    m = {8'h00}; run_msg(m, 0, 0);

    // 256-byte message: padding length wraps to zero.
    m = {}; for (int i = 0; i < 256; i++) m.push_back(8'($urandom));
    w = build_words(m);
    chk("pin_len256_words", w.size(), 33);
    chk("pin_len256_pad", w[32], 64'h0);
    run_msg(m, 2, 0);

    // Randomized messages and keys.
    for (int t = 0; t < 30; t++) begin
      i_key = {$urandom, $urandom, $urandom, $urandom};
      m = {};
      c = $urandom_range(1, 40);
      for (int i = 0; i < c; i++) m.push_back(8'($urandom));
      run_msg(m, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
